// File: rtl/irq_pkg.sv
// Shared constants for the 68040 interrupt controller.
package irq_pkg;

    localparam int NLEVELS = 7;

    localparam logic [3:0] ADDR_PEND  = 4'h0;
    localparam logic [3:0] ADDR_MASK  = 4'h1;
    localparam logic [3:0] ADDR_EDGE  = 4'h2;
    localparam logic [3:0] ADDR_SWSET = 4'h3;

    localparam logic [7:0] VEC_BASE_DEF = 8'h40;
    localparam logic [7:0] SPUR_VEC_DEF = 8'h18;

endpackage

// File: rtl/irq_prio_enc.sv
// 7-to-3 highest-set-bit encoder: returns bit index + 1, or 0 when nothing is set.
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [NLEVELS-1:0] act,
    output logic [2:0]         lvl
);

    // Scan upward so the highest active level overwrites lower ones.
    always_comb begin
        lvl = 3'd0;
        for (int i = 0; i < NLEVELS; i++) begin
            if (act[i]) lvl = 3'(i + 1);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises 7 sources, keeps mask/edge/pending state,
// drives the active-low IPL and answers IACK cycles with a vector.
// Handshakes: fpga_stb and iack_stb are one-cycle pulses; the matching
// fpga_ack / iack_ack is a one-cycle pulse exactly one cycle later with its
// data valid in that same cycle. No backpressure; back-to-back strobes are legal.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter logic [7:0] VEC_BASE = VEC_BASE_DEF,
    parameter logic [7:0] SPUR_VEC = SPUR_VEC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  src_irq,
    input  logic        fpga_stb,
    input  logic        fpga_we,
    input  logic [3:0]  fpga_addr,
    input  logic [7:0]  fpga_data,
    output logic        fpga_ack,
    output logic [31:0] fpga_odata,
    input  logic        iack_stb,
    input  logic [2:0]  iack_level,
    output logic        iack_ack,
    output logic [7:0]  iack_vec,
    output logic [2:0]  out_ipl
);

    logic [6:0]  s1, s2, s3;
    logic [6:0]  pend, mask, edge_en;
    logic [6:0]  act, w1c, swset, set_bits, clr_bits, pend_nxt;
    logic [6:0]  iack_sel, iack_clr;
    logic        iack_hit;
    logic        wr;
    logic [31:0] rd_data;
    logic [2:0]  lvl;

    // Only 7 levels exist; the top data bit has no register behind it.
    logic unused_data_msb;
    assign unused_data_msb = fpga_data[7];

    irq_prio_enc u_enc (
        .act (act),
        .lvl (lvl)
    );

    // Next-state pending bits, IACK match and read mux.
    always_comb begin
        act      = pend & mask;
        wr       = fpga_stb & fpga_we;
        w1c      = (wr && fpga_addr == ADDR_PEND)  ? fpga_data[6:0] : 7'd0;
        swset    = (wr && fpga_addr == ADDR_SWSET) ? fpga_data[6:0] : 7'd0;
        iack_sel = (iack_stb && iack_level != 3'd0) ? (7'd1 << (iack_level - 3'd1)) : 7'd0;
        iack_hit = |(iack_sel & act);
        iack_clr = iack_sel & act & edge_en;
        set_bits = (s2 & ~s3) | swset;
        clr_bits = w1c | iack_clr;
        // Edge bits: set beats clear. Level bits simply track the synchronised input.
        pend_nxt = (edge_en & ((pend & ~clr_bits) | set_bits)) | (~edge_en & s2);
        case (fpga_addr)
            ADDR_PEND: rd_data = {25'd0, pend};
            ADDR_MASK: rd_data = {25'd0, mask};
            ADDR_EDGE: rd_data = {25'd0, edge_en};
            default:   rd_data = 32'd0;
        endcase
    end

    // Synchroniser, configuration/pending state, handshake responses and IPL register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1         <= 7'd0;
            s2         <= 7'd0;
            s3         <= 7'd0;
            pend       <= 7'd0;
            mask       <= 7'd0;
            edge_en    <= 7'd0;
            fpga_ack   <= 1'b0;
            fpga_odata <= 32'd0;
            iack_ack   <= 1'b0;
            iack_vec   <= 8'd0;
            out_ipl    <= 3'b111;
        end else begin
            s1      <= src_irq;
            s2      <= s1;
            s3      <= s2;
            pend    <= pend_nxt;
            out_ipl <= ~lvl;
            if (wr && fpga_addr == ADDR_MASK) mask    <= fpga_data[6:0];
            if (wr && fpga_addr == ADDR_EDGE) edge_en <= fpga_data[6:0];
            fpga_ack <= fpga_stb;
            if (fpga_stb) fpga_odata <= rd_data;
            iack_ack <= iack_stb;
            if (iack_stb) iack_vec <= iack_hit ? (VEC_BASE + {5'd0, iack_level}) : SPUR_VEC;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register table plus hand-written multi-cycle sequences.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  src_irq = 7'd0;
    logic        fpga_stb = 1'b0;
    logic        fpga_we = 1'b0;
    logic [3:0]  fpga_addr = 4'd0;
    logic [7:0]  fpga_data = 8'd0;
    logic        fpga_ack;
    logic [31:0] fpga_odata;
    logic        iack_stb = 1'b0;
    logic [2:0]  iack_level = 3'd0;
    logic        iack_ack;
    logic [7:0]  iack_vec;
    logic [2:0]  out_ipl;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp;   // expected read data (reads only)
    } vec_t;

    vec_t tbl[14];

    irq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .src_irq    (src_irq),
        .fpga_stb   (fpga_stb),
        .fpga_we    (fpga_we),
        .fpga_addr  (fpga_addr),
        .fpga_data  (fpga_data),
        .fpga_ack   (fpga_ack),
        .fpga_odata (fpga_odata),
        .iack_stb   (iack_stb),
        .iack_level (iack_level),
        .iack_ack   (iack_ack),
        .iack_vec   (iack_vec),
        .out_ipl    (out_ipl)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Called just after a negedge; drives one access and returns the acked read data.
    task automatic reg_access(input logic we, input logic [3:0] addr, input logic [7:0] data,
                              output logic [31:0] rd);
        fpga_stb  = 1'b1;
        fpga_we   = we;
        fpga_addr = addr;
        fpga_data = data;
        @(negedge clk);
        fpga_stb = 1'b0;
        fpga_we  = 1'b0;
        check("fpga_ack", {31'd0, fpga_ack}, 32'd1);
        rd = fpga_odata;
    endtask

    task automatic reg_wr(input logic [3:0] addr, input logic [7:0] data);
        logic [31:0] rd;
        reg_access(1'b1, addr, data, rd);
    endtask

    task automatic reg_rd_check(input string name, input logic [3:0] addr, input logic [7:0] exp);
        logic [31:0] rd;
        reg_access(1'b0, addr, 8'd0, rd);
        check(name, rd, {24'd0, exp});
    endtask

    task automatic iack_check(input string name, input logic [2:0] lvl, input logic [7:0] exp);
        iack_stb   = 1'b1;
        iack_level = lvl;
        @(negedge clk);
        iack_stb = 1'b0;
        check({name, "_ack"}, {31'd0, iack_ack}, 32'd1);
        check(name, {24'd0, iack_vec}, {24'd0, exp});
    endtask

    initial begin
        logic [31:0] rd;

        // Register table: src_irq idle, so level bits of PEND stay 0.
        tbl[0]  = '{1'b1, 4'h1, 8'h55, 8'h00};
        tbl[1]  = '{1'b0, 4'h1, 8'h00, 8'h55};
        tbl[2]  = '{1'b1, 4'h2, 8'h2A, 8'h00};
        tbl[3]  = '{1'b0, 4'h2, 8'h00, 8'h2A};
        tbl[4]  = '{1'b0, 4'h3, 8'h00, 8'h00};
        tbl[5]  = '{1'b1, 4'h5, 8'hFF, 8'h00};
        tbl[6]  = '{1'b0, 4'h5, 8'h00, 8'h00};
        tbl[7]  = '{1'b0, 4'h0, 8'h00, 8'h00};
        tbl[8]  = '{1'b1, 4'h3, 8'h0F, 8'h00};  // only edge bits 1,3 take
        tbl[9]  = '{1'b0, 4'h0, 8'h00, 8'h0A};
        tbl[10] = '{1'b1, 4'h0, 8'h02, 8'h00};
        tbl[11] = '{1'b0, 4'h0, 8'h00, 8'h08};
        tbl[12] = '{1'b1, 4'h0, 8'h08, 8'h00};
        tbl[13] = '{1'b0, 4'h0, 8'h00, 8'h00};

        // reset
        tick(3);
        check("rst_ipl", {29'd0, out_ipl}, 32'h7);
        check("rst_fpga_ack", {31'd0, fpga_ack}, 32'd0);
        check("rst_iack_ack", {31'd0, iack_ack}, 32'd0);
        check("rst_odata", fpga_odata, 32'd0);
        check("rst_vec", {24'd0, iack_vec}, 32'd0);
        rst = 1'b0;
        tick(1);

        for (int i = 0; i < 14; i++) begin
            reg_access(tbl[i].we, tbl[i].addr, tbl[i].data, rd);
            if (!tbl[i].we) check($sformatf("tbl_rd_%0d", i), rd, {24'd0, tbl[i].exp});
        end
        check("tbl_ipl_idle", {29'd0, out_ipl}, 32'h7);

        // Level source: latency and drop.
        reg_wr(4'h1, 8'h7F);
        reg_wr(4'h2, 8'h00);
        tick(2);
        src_irq[4] = 1'b1;
        tick(3);
        check("lvl_ipl_3cyc", {29'd0, out_ipl}, 32'h7);
        tick(1);
        check("lvl_ipl_4cyc", {29'd0, out_ipl}, 32'h2);
        reg_wr(4'h0, 8'h10);  // W1C ignored on level bit
        reg_rd_check("lvl_w1c_noeffect", 4'h0, 8'h10);
        src_irq[4] = 1'b0;
        tick(5);
        check("lvl_ipl_drop", {29'd0, out_ipl}, 32'h7);

        // Edge sources and IACK.
        reg_wr(4'h2, 8'h7F);
        src_irq = 7'b0100010;
        tick(1);
        src_irq = 7'd0;
        tick(6);
        check("edge_ipl6", {29'd0, out_ipl}, {29'd0, ~3'd6});
        iack_check("iack6", 3'd6, 8'h46);
        reg_rd_check("pend_after_iack6", 4'h0, 8'h02);
        check("ipl_after_iack6", {29'd0, out_ipl}, {29'd0, ~3'd2});
        iack_check("iack3_spur", 3'd3, 8'h18);
        reg_rd_check("pend_after_spur", 4'h0, 8'h02);
        iack_check("iack0_spur", 3'd0, 8'h18);

        // Simultaneous W1C and IACK on the same bit.
        iack_stb   = 1'b1;
        iack_level = 3'd2;
        reg_wr(4'h0, 8'h02);
        iack_stb = 1'b0;
        check("iack2_vec_concurrent", {24'd0, iack_vec}, 32'h42);
        reg_rd_check("pend_after_concurrent", 4'h0, 8'h00);

        // Back-to-back IACKs.
        reg_wr(4'h3, 8'h06);
        iack_stb   = 1'b1;
        iack_level = 3'd3;
        @(negedge clk);
        check("b2b_ack1", {31'd0, iack_ack}, 32'd1);
        check("b2b_vec1", {24'd0, iack_vec}, 32'h43);
        iack_level = 3'd2;
        @(negedge clk);
        iack_stb = 1'b0;
        check("b2b_ack2", {31'd0, iack_ack}, 32'd1);
        check("b2b_vec2", {24'd0, iack_vec}, 32'h42);
        @(negedge clk);
        check("b2b_ack_drop", {31'd0, iack_ack}, 32'd0);
        reg_rd_check("pend_after_b2b", 4'h0, 8'h00);

        // SWSET under mask.
        reg_wr(4'h1, 8'h00);
        reg_wr(4'h2, 8'h01);
        reg_wr(4'h3, 8'h01);
        reg_rd_check("swset_pend", 4'h0, 8'h01);
        tick(1);
        check("swset_masked_ipl", {29'd0, out_ipl}, 32'h7);
        reg_wr(4'h1, 8'h01);
        tick(1);
        check("swset_unmasked_ipl", {29'd0, out_ipl}, 32'h6);
        reg_wr(4'h0, 8'h01);
        reg_rd_check("swset_cleared", 4'h0, 8'h00);

        // Edge on bit 2 in the same cycle as its W1C: set wins.
        reg_wr(4'h2, 8'h04);
        reg_wr(4'h3, 8'h04);
        src_irq[2] = 1'b1;
        tick(2);
        reg_wr(4'h0, 8'h04);
        reg_rd_check("set_beats_clr", 4'h0, 8'h04);
        reg_wr(4'h0, 8'h04);
        reg_rd_check("clr_after", 4'h0, 8'h00);
        src_irq[2] = 1'b0;

        // Reset mid-access with active IPL.
        reg_wr(4'h1, 8'h7F);
        reg_wr(4'h3, 8'h04);
        tick(1);
        check("pre_rst_ipl", {29'd0, out_ipl}, {29'd0, ~3'd3});
        fpga_stb   = 1'b1;
        fpga_we    = 1'b0;
        fpga_addr  = 4'h1;
        iack_stb   = 1'b1;
        iack_level = 3'd3;
        #2 rst = 1'b1;
        #1;
        check("rst_async_ipl", {29'd0, out_ipl}, 32'h7);
        @(negedge clk);
        fpga_stb = 1'b0;
        iack_stb = 1'b0;
        check("rst_no_fpga_ack", {31'd0, fpga_ack}, 32'd0);
        check("rst_no_iack_ack", {31'd0, iack_ack}, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("rst_still_no_ack", {31'd0, fpga_ack}, 32'd0);
        reg_rd_check("rst_pend", 4'h0, 8'h00);
        reg_rd_check("rst_mask", 4'h1, 8'h00);
        reg_rd_check("rst_edge", 4'h2, 8'h00);
        check("rst_ipl_after", {29'd0, out_ipl}, 32'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller feeding the 68040 IPL pins and sitting directly upstream of the CPU's interrupt input.
- Collects 7 peripheral interrupt sources, one per priority level 1..7, applies mask and edge/level configuration, and drives the encoded active-low IPL.
- Answers CPU interrupt-acknowledge (IACK) cycles with a vector.
- Register access uses the same strobe/ack interface as the other FPGA register blocks.

Parameters:
- VEC_BASE, 8'h40, vector returned for level L is VEC_BASE+L.
- SPUR_VEC, 8'h18, vector returned for an IACK with no matching pending source (68k spurious vector 24).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- src_irq  in  7  raw interrupt sources, active-high, asynchronous to clk; bit i is level i+1.
- fpga_stb  in  1  register access strobe, one-cycle pulse.
- fpga_we  in  1  1=write, 0=read; qualified by fpga_stb.
- fpga_addr  in  4  register select.
- fpga_data  in  8  write data.
- fpga_ack  out  1  access acknowledge, one-cycle pulse.
- fpga_odata  out  32  read data; bits 31:8 are zero.
- iack_stb  in  1  IACK cycle strobe from the bus decoder, one-cycle pulse.
- iack_level  in  3  level being acknowledged (1..7).
- iack_ack  out  1  IACK acknowledge, one-cycle pulse.
- iack_vec  out  8  vector, valid while iack_ack=1.
- out_ipl  out  3  encoded interrupt level to CPU, active-low.

Behaviour:

Reset (async, rst=1):
- pend=0, mask=0, edge=0, sync flops=0.
- out_ipl=3'b111.
- fpga_ack=0, iack_ack=0, fpga_odata=0, iack_vec=0.
- Any access in flight is dropped; no ack is issued for it.

Input synchronisation:
- src_irq passes through 2 flops (s1, s2); s3 is a delayed copy of s2 for edge detection.

Pending logic, per bit i:
- edge[i]=1: pend[i] is set on s2&~s3. It clears on a W1C write to PEND or on an IACK that matches level i+1.
- edge[i]=0: pend[i]=s2[i] every cycle. W1C and IACK have no effect.
- If a set and a clear land on the same bit in the same cycle, the set wins.

Registers:
- 0x0 PEND: read returns pend[6:0]. A write clears each bit written as 1 (W1C), edge bits only.
- 0x1 MASK: R/W; 1 = enabled.
- 0x2 EDGE: R/W; 1 = edge-triggered.
- 0x3 SWSET: a write sets pend bits written as 1, edge bits only. Reads return 0.
- Other addresses: writes are ignored, reads return 0; the access is still acked.
- Write takes effect on the fpga_stb cycle.
- fpga_ack=1 exactly one cycle after fpga_stb, with fpga_odata valid in the same cycle.

Priority encode:
- act = pend & mask.
- lvl = index of the highest set bit of act, plus 1; lvl=0 if act=0.
- out_ipl <= ~lvl, registered, giving 1 cycle of latency from a pend/mask change to out_ipl.
- Latency from a src_irq rising edge to out_ipl: 4 cycles, counted as 2 sync + edge/pend + ipl register.

IACK:
- On iack_stb, sample L=iack_level.
- If L in 1..7 and act[L-1]=1: vector = VEC_BASE+L; if edge[L-1]=1, clear pend[L-1].
- Otherwise: vector = SPUR_VEC, and no state changes.
- iack_ack=1 and iack_vec are valid exactly one cycle after iack_stb.
- iack_stb together with fpga_stb: both are serviced independently in the same cycle. A W1C and an IACK clear on the same bit are harmless, since both clear.
- A back-to-back strobe on the next cycle is legal; each strobe gets its own ack.

Decomposition:
- Shared package irq_pkg: register address constants (PEND/MASK/EDGE/SWSET), SPUR_VEC default, NLEVELS=7.
- One sub-module, irq_prio_enc: combinational 7-to-3 highest-bit encoder.
- Everything else stays in irq_ctrl.

Test Plan:
- Reset, then MASK=0x7F, EDGE=0x00, src_irq[4]=1 -> out_ipl=3'b010 (level 5) 4 cycles later; drop src_irq[4] -> out_ipl returns to 3'b111.
- EDGE=0x7F, MASK=0x7F, pulse src_irq[1] and src_irq[5] -> out_ipl=~6; IACK level 6 -> iack_vec=0x46, pend=0x02, out_ipl=~2.
- IACK level 3 with nothing pending -> iack_vec=0x18 and pend unchanged.
- EDGE bit 0 set, SWSET write 0x01 while MASK=0 -> PEND reads 0x01 and out_ipl=3'b111; MASK=0x01 -> out_ipl=3'b110; PEND write 0x01 -> cleared.
- Edge arrives on bit 2 in the same cycle as a W1C clear of bit 2 -> PEND bit 2 remains 1.
- Assert rst between fpga_stb and fpga_ack, and during active IPL -> no ack is issued, out_ipl=3'b111 immediately, all registers read 0.
